// File: rtl/replay_reader_pkg.sv
// Shared replay types: reader FSM states, record geometry, field indices
// and the coordinate slicer used by both the reader and the renderer.
// Pure declarations; no logic or timing of its own.
package replay_pkg;

  localparam int COORD_W    = 12;
  localparam int NUM_COORDS = 12;
  localparam int REC_W      = COORD_W * NUM_COORDS;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Field k of a record sits at bits [12k+11:12k].
  localparam int F_A_X1  = 0;
  localparam int F_A_X2  = 1;
  localparam int F_A_Y1  = 2;
  localparam int F_A_Y2  = 3;
  localparam int F_B_X1  = 4;
  localparam int F_B_X2  = 5;
  localparam int F_B_Y1  = 6;
  localparam int F_B_Y2  = 7;
  localparam int F_B1_X1 = 8;
  localparam int F_B1_X2 = 9;
  localparam int F_B1_Y1 = 10;
  localparam int F_B1_Y2 = 11;

  // Extract coordinate k from a flat record. A shift keeps the select
  // constant-width regardless of the index type.
  function automatic coord_t get_field(input logic [REC_W-1:0] rec, input int unsigned k);
    logic [REC_W-1:0] sh;
    sh = rec >> (k * COORD_W);
    return sh[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/replay_reader_if.sv
// Bundle of the reader's control, bram read port and renderer handshake.
// Wires only; timing is defined by the modules on either side.
// master = replay_reader, slave = its environment (bram, renderer, control).
interface replay_reader_if #(
  parameter int RAM_WIDTH     = 144,
  parameter int RAM_ADDR_BITS = 9
);

  logic                     start_i;
  logic                     stop_i;
  logic [RAM_ADDR_BITS-1:0] end_addr_i;
  logic                     frame_tick_i;
  logic                     ram_enable_o;
  logic [RAM_ADDR_BITS-1:0] address_o;
  logic [RAM_WIDTH-1:0]     ram_data_i;
  logic [RAM_WIDTH-1:0]     frame_data_o;
  logic                     frame_valid_o;
  logic                     frame_ready_i;
  logic                     busy_o;
  logic                     done_o;

  modport master (
    input  start_i, stop_i, end_addr_i, frame_tick_i, ram_data_i, frame_ready_i,
    output ram_enable_o, address_o, frame_data_o, frame_valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, stop_i, end_addr_i, frame_tick_i, ram_data_i, frame_ready_i,
    input  ram_enable_o, address_o, frame_data_o, frame_valid_o, busy_o, done_o
  );

endinterface

// File: rtl/frame_unpack.sv
// Renderer-side split of a flat replay record into its twelve coordinates.
// Purely combinational, zero latency.
// No flow control; follows whatever record is on its input.
module frame_unpack
  import replay_pkg::*;
(
  input  logic [REC_W-1:0] frame_i,
  output coord_t           coord_o [NUM_COORDS]
);

  // Slice every field with the shared helper so reader and renderer agree on layout
  always_comb begin
    for (int k = 0; k < NUM_COORDS; k++) begin
      coord_o[k] = get_field(frame_i, unsigned'(k));
    end
  end

endmodule

// File: rtl/replay_reader.sv
// Replays recorded game-state records 0..end_q from bram, one per display frame.
// Latency: FETCH at cycle n, record captured at edge n+1, frame_valid from n+2.
// Backpressure: holds frame_valid until accepted; advances on accept + frame tick.
// Build option REPLAY_LOOP_EN: wrap to record 0 after end_q instead of stopping in DONE.
module replay_reader
  import replay_pkg::*;
#(
  parameter int RAM_WIDTH     = 144,
  parameter int RAM_ADDR_BITS = 9,
  parameter int COORD_W       = 12,
  parameter int NUM_COORDS    = 12
) (
  input logic            clock,
  input logic            reset_n,
  replay_reader_if.master bus
);

  if (RAM_WIDTH != NUM_COORDS * COORD_W) begin : g_bad_width
    $error("replay_reader: RAM_WIDTH must equal NUM_COORDS*COORD_W");
  end

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_FETCH   = ST_FETCH;
  localparam logic [2:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [2:0] S_PRESENT = ST_PRESENT;
  localparam logic [2:0] S_DONE    = ST_DONE;

  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = RAM_ADDR_BITS'(1);

  logic [2:0]               state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] address_q, address_d;
  logic [RAM_ADDR_BITS-1:0] end_q, end_d;
  logic [RAM_WIDTH-1:0]     frame_data_q, frame_data_d;
  logic                     frame_valid_q, frame_valid_d;
  logic                     ram_enable_q, ram_enable_d;
  logic                     tick_pending_q, tick_pending_d;
  logic                     accepted_q, accepted_d;

  logic handshake;
  logic have_record;
  logic have_tick;
  logic advance;
  logic at_end;

  // Advance qualifiers: record taken (now or earlier) and a frame tick seen (now or earlier)
  always_comb begin
    handshake   = (state_q == S_PRESENT) && frame_valid_q && bus.frame_ready_i;
    have_record = accepted_q || handshake;
    have_tick   = bus.frame_tick_i || tick_pending_q;
    advance     = (state_q == S_PRESENT) && have_record && have_tick;
    at_end      = (address_q == end_q);
  end

  // Next-state logic; stop overrides everything, address and frame_data hold on stop
  always_comb begin
    state_d        = state_q;
    address_d      = address_q;
    end_d          = end_q;
    frame_data_d   = frame_data_q;
    frame_valid_d  = frame_valid_q;
    tick_pending_d = tick_pending_q;
    accepted_d     = accepted_q;

    if (bus.stop_i) begin
      state_d        = S_IDLE;
      frame_valid_d  = 1'b0;
      tick_pending_d = 1'b0;
      accepted_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start_i) begin
            state_d        = S_FETCH;
            address_d      = '0;
            end_d          = bus.end_addr_i;
            tick_pending_d = 1'b0;
            accepted_d     = 1'b0;
          end
        end

        S_FETCH: begin
          state_d = S_CAPTURE;
          if (bus.frame_tick_i) tick_pending_d = 1'b1;
        end

        S_CAPTURE: begin
          state_d       = S_PRESENT;
          frame_data_d  = bus.ram_data_i;
          frame_valid_d = 1'b1;
          if (bus.frame_tick_i) tick_pending_d = 1'b1;
        end

        S_PRESENT: begin
          if (handshake) begin
            frame_valid_d = 1'b0;
            accepted_d    = 1'b1;
          end
          if (advance) begin
            tick_pending_d = 1'b0;
            accepted_d     = 1'b0;
            if (at_end) begin
`ifdef REPLAY_LOOP_EN
              state_d   = S_FETCH;
              address_d = '0;
`else
              state_d   = S_DONE;
`endif
            end else begin
              state_d   = S_FETCH;
              address_d = address_q + ADDR_ONE;
            end
          end else if (bus.frame_tick_i) begin
            // Tick arrived before the renderer took the record: remember one
            tick_pending_d = 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Enable is registered and tracks the FETCH state exactly
    ram_enable_d = (state_d == S_FETCH);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      address_q      <= '0;
      end_q          <= '0;
      frame_data_q   <= '0;
      frame_valid_q  <= 1'b0;
      ram_enable_q   <= 1'b0;
      tick_pending_q <= 1'b0;
      accepted_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      address_q      <= address_d;
      end_q          <= end_d;
      frame_data_q   <= frame_data_d;
      frame_valid_q  <= frame_valid_d;
      ram_enable_q   <= ram_enable_d;
      tick_pending_q <= tick_pending_d;
      accepted_q     <= accepted_d;
    end
  end

  assign bus.ram_enable_o  = ram_enable_q;
  assign bus.address_o     = address_q;
  assign bus.frame_data_o  = frame_data_q;
  assign bus.frame_valid_o = frame_valid_q;
  assign bus.busy_o        = (state_q == S_FETCH) || (state_q == S_CAPTURE) ||
                             (state_q == S_PRESENT);
  assign bus.done_o        = (state_q == S_DONE);

  // The bram port is only ever enabled while fetching
  a_ren_in_fetch : assert property (@(posedge clock) disable iff (!reset_n)
    ram_enable_q |-> (state_q == S_FETCH));

  // A record is only offered while presenting
  a_valid_in_present : assert property (@(posedge clock) disable iff (!reset_n)
    frame_valid_q |-> (state_q == S_PRESENT));

endmodule

// File: tb/tb_replay_reader.sv
module tb_replay_reader;
  import replay_pkg::*;

  localparam int AW = 9;
  localparam int DW = 144;

  typedef struct {
    logic          start;
    logic          stop;
    logic [AW-1:0] end_addr;
    logic          tick;
    logic          ready;
    logic          e_ren;
    logic [AW-1:0] e_addr;
    logic          e_fv;
    logic          e_busy;
    logic          e_done;
    logic [11:0]   e_ax1;
    logic [11:0]   e_b1y2;
  } vec_t;

  logic   clock = 1'b0;
  logic   reset_n = 1'b0;
  int     n_tests = 0;
  int     n_fail = 0;
  logic [DW-1:0] mem [16];
  vec_t   vecs [$];
  int     fetch_log [$];
  int     done_seen;
  coord_t coords [NUM_COORDS];

  replay_reader_if #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW)) bus ();

  replay_reader #(
    .RAM_WIDTH(DW), .RAM_ADDR_BITS(AW), .COORD_W(12), .NUM_COORDS(12)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  frame_unpack u_unpack (.frame_i(bus.frame_data_o), .coord_o(coords));

  always #5 clock = ~clock;

  // Synchronous-read bram: data appears the cycle after enable
  always @(posedge clock) begin
    if (bus.ram_enable_o) bus.ram_data_i <= mem[bus.address_o[3:0]];
  end

  // Record n carries coordinate values 12n .. 12n+11 in fields 0..11
  function automatic logic [DW-1:0] mk_rec(input int n);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < 12; k++) r = r | (DW'(12 * n + k) << (12 * k));
    return r;
  endfunction

  function automatic vec_t V(input logic st, input logic sp, input int ea, input logic tk,
                             input logic rd, input logic ren, input int addr, input logic fv,
                             input logic bz, input logic dn, input int ax1, input int b1y2);
    vec_t v;
    v.start = st; v.stop = sp; v.end_addr = AW'(ea); v.tick = tk; v.ready = rd;
    v.e_ren = ren; v.e_addr = AW'(addr); v.e_fv = fv; v.e_busy = bz; v.e_done = dn;
    v.e_ax1 = 12'(ax1); v.e_b1y2 = 12'(b1y2);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic ren, input int addr,
                             input logic fv, input logic bz, input logic dn);
    check({tag, ".ram_enable"},  32'(bus.ram_enable_o),  32'(ren));
    check({tag, ".address"},     32'(bus.address_o),     32'(addr));
    check({tag, ".frame_valid"}, 32'(bus.frame_valid_o), 32'(fv));
    check({tag, ".busy"},        32'(bus.busy_o),        32'(bz));
    check({tag, ".done"},        32'(bus.done_o),        32'(dn));
  endtask

  task automatic expect_fields(input string tag, input int ax1, input int b1y2);
    check({tag, ".a_x1"},  32'(coords[F_A_X1]),  32'(ax1));
    check({tag, ".b1_y2"}, 32'(coords[F_B1_Y2]), 32'(b1y2));
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.frame_tick_i = 1'b0;
    bus.end_addr_i = '0;
  endtask

  initial begin
    clear_inputs();
    bus.frame_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = mk_rec(i);

    //           st sp ea tk rd | ren addr fv bz dn ax1 b1y2
    vecs.push_back(V(1, 0, 2, 0, 1,  1, 0, 0, 1, 0,  0,  0)); // start -> FETCH
    vecs.push_back(V(0, 0, 0, 0, 1,  0, 0, 0, 1, 0,  0,  0)); // CAPTURE
    vecs.push_back(V(0, 0, 0, 0, 1,  0, 0, 1, 1, 0,  0, 11)); // PRESENT rec0
    vecs.push_back(V(0, 0, 0, 0, 1,  0, 0, 0, 1, 0,  0, 11)); // accepted, wait tick
    vecs.push_back(V(0, 0, 0, 1, 1,  1, 1, 0, 1, 0,  0, 11)); // tick -> FETCH addr1
    vecs.push_back(V(1, 0, 0, 0, 1,  0, 1, 0, 1, 0,  0, 11)); // start while busy ignored
    vecs.push_back(V(0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 12, 23)); // PRESENT rec1
    vecs.push_back(V(0, 0, 0, 1, 1,  1, 2, 0, 1, 0, 12, 23)); // accept+tick same edge
    vecs.push_back(V(0, 0, 0, 0, 1,  0, 2, 0, 1, 0, 12, 23)); // CAPTURE
    vecs.push_back(V(0, 0, 0, 1, 0,  0, 2, 1, 1, 0, 24, 35)); // tick in CAPTURE pends
`ifdef REPLAY_LOOP_EN
    vecs.push_back(V(0, 0, 0, 0, 1,  1, 0, 0, 1, 0, 24, 35)); // end -> wrap to addr0
    vecs.push_back(V(0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 24, 35)); // stop -> IDLE
`else
    vecs.push_back(V(0, 0, 0, 0, 1,  0, 2, 0, 0, 1, 24, 35)); // end -> DONE
    vecs.push_back(V(0, 0, 0, 1, 1,  0, 2, 0, 0, 1, 24, 35)); // tick in DONE ignored
    vecs.push_back(V(1, 0, 0, 0, 1,  1, 0, 0, 1, 0, 24, 35)); // restart, end_addr=0
    vecs.push_back(V(0, 0, 5, 1, 1,  0, 0, 0, 1, 0, 24, 35)); // CAPTURE, tick pends
    vecs.push_back(V(0, 0, 5, 0, 0,  0, 0, 1, 1, 0,  0, 11)); // PRESENT rec0
    vecs.push_back(V(0, 0, 5, 0, 1,  0, 0, 0, 0, 1,  0, 11)); // single record -> DONE
`endif

    // Reset state
    repeat (2) @(negedge clock);
    expect_outs("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    expect_fields("reset", 0, 0);
    reset_n = 1'b1;
    cyc();

    // Table-driven main sequence
    for (int i = 0; i < vecs.size(); i++) begin
      bus.start_i = vecs[i].start; bus.stop_i = vecs[i].stop;
      bus.end_addr_i = vecs[i].end_addr; bus.frame_tick_i = vecs[i].tick;
      bus.frame_ready_i = vecs[i].ready;
      cyc();
      expect_outs($sformatf("v%0d", i), vecs[i].e_ren, int'(vecs[i].e_addr),
                  vecs[i].e_fv, vecs[i].e_busy, vecs[i].e_done);
      expect_fields($sformatf("v%0d", i), int'(vecs[i].e_ax1), int'(vecs[i].e_b1y2));
    end
    clear_inputs();
    bus.frame_ready_i = 1'b0;
    cyc();

    // Stalled renderer with three ticks: one pending tick, one advance
    bus.start_i = 1'b1; bus.end_addr_i = 9'd3;
    cyc();
    clear_inputs();
    for (int i = 0; i < 50; i++) begin
      bus.frame_tick_i = (i == 5 || i == 20 || i == 35);
      cyc();
    end
    bus.frame_tick_i = 1'b0;
    expect_outs("stall", 1'b0, 0, 1'b1, 1'b1, 1'b0);
    bus.frame_ready_i = 1'b1;
    cyc();
    expect_outs("stall_accept", 1'b1, 1, 1'b0, 1'b1, 1'b0);
    repeat (20) cyc();
    expect_outs("stall_one_adv", 1'b0, 1, 1'b0, 1'b1, 1'b0);

    // Tick during FETCH is remembered; advance on acceptance alone
    bus.frame_ready_i = 1'b0;
    bus.frame_tick_i = 1'b1;
    cyc();
    check("ftick.adv_addr", 32'(bus.address_o), 32'd2);
    check("ftick.fetch", 32'(bus.ram_enable_o), 32'd1);
    cyc();
    bus.frame_tick_i = 1'b0;
    cyc();
    check("ftick.valid", 32'(bus.frame_valid_o), 32'd1);
    expect_fields("ftick", 24, 35);
    repeat (5) cyc();
    check("ftick.hold_addr", 32'(bus.address_o), 32'd2);
    bus.frame_ready_i = 1'b1;
    cyc();
    expect_outs("ftick_accept", 1'b1, 3, 1'b0, 1'b1, 1'b0);

    // Stop (with a competing start) during CAPTURE
    cyc();
    check("capture.busy", 32'(bus.busy_o), 32'd1);
    bus.stop_i = 1'b1; bus.start_i = 1'b1;
    cyc();
    clear_inputs();
    expect_outs("stop", 1'b0, 3, 1'b0, 1'b0, 1'b0);
    expect_fields("stop", 24, 35);
    repeat (3) cyc();
    check("stop.idle_ren", 32'(bus.ram_enable_o), 32'd0);

    // Reset while presenting record 1 with a tick pending
    bus.frame_ready_i = 1'b0;
    bus.start_i = 1'b1; bus.end_addr_i = 9'd1;
    cyc();
    clear_inputs();
    cyc(); cyc();
    bus.frame_ready_i = 1'b1;
    cyc();
    bus.frame_ready_i = 1'b0;
    bus.frame_tick_i = 1'b1;
    cyc();
    bus.frame_tick_i = 1'b0;
    cyc(); cyc();
    expect_outs("pre_reset", 1'b0, 1, 1'b1, 1'b1, 1'b0);
    bus.frame_tick_i = 1'b1;
    cyc();
    bus.frame_tick_i = 1'b0;
    reset_n = 1'b0;
    repeat (3) cyc();
    expect_outs("mid_reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    expect_fields("mid_reset", 0, 0);
    reset_n = 1'b1;
    cyc();

    // end_addr=1 replay: address sequence and termination
    bus.frame_ready_i = 1'b1;
    bus.start_i = 1'b1; bus.end_addr_i = 9'd1;
    cyc();
    clear_inputs();
    done_seen = 0;
    if (bus.ram_enable_o) fetch_log.push_back(int'(bus.address_o));
    for (int c = 0; c < 80; c++) begin
      bus.frame_tick_i = (c % 10 == 9);
      cyc();
      if (bus.ram_enable_o) fetch_log.push_back(int'(bus.address_o));
      if (bus.done_o) done_seen++;
    end
    bus.frame_tick_i = 1'b0;
`ifdef REPLAY_LOOP_EN
    check("loop.enough_fetches", 32'(fetch_log.size() >= 4), 32'd1);
    for (int i = 0; i < fetch_log.size(); i++)
      check($sformatf("loop.addr%0d", i), 32'(fetch_log[i]), 32'(i % 2));
    check("loop.done_never", 32'(done_seen), 32'd0);
    bus.stop_i = 1'b1;
    cyc();
    bus.stop_i = 1'b0;
`else
    check("end1.fetches", 32'(fetch_log.size()), 32'd2);
    for (int i = 0; i < fetch_log.size(); i++)
      check($sformatf("end1.addr%0d", i), 32'(fetch_log[i]), 32'(i % 2));
    expect_outs("end1_final", 1'b0, 1, 1'b0, 1'b0, 1'b1);
    expect_fields("end1_final", 12, 23);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
